// File: rtl/intp_pkg.sv
// intp_pkg: shared definitions for the priority interrupt controller.
//   - state_e: arbitration FSM states (idle, select, grant).
//   - id_width(): index width for a given source count (at least 1 bit).
//   - prio_base(), pending_ofs(), mode_ofs(): APB word offsets of the register
//     map, derived from the source count.
package intp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSelect,
        StGrant
    } state_e;

    function automatic int unsigned id_width(input int unsigned num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

    // PRIO[i] lives at prio_base() + i.
    function automatic int unsigned prio_base();
        return 0;
    endfunction

    function automatic int unsigned pending_ofs(input int unsigned num_src);
        return prio_base() + num_src;
    endfunction

    function automatic int unsigned mode_ofs(input int unsigned num_src);
        return prio_base() + num_src + 1;
    endfunction

endpackage

// File: rtl/intp_prio_arbiter.sv
// intp_prio_arbiter: combinational winner selection.
//   pend_i     - pending bit per source
//   prio_i     - priority per source, 0 = disabled
//   win_idx_o  - highest-priority eligible source, lowest index on a tie
//   win_any_o  - at least one source is eligible
module intp_prio_arbiter #(
    parameter int unsigned NUM_SRC    = 16,
    parameter int unsigned PRIO_WIDTH = 4,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic [NUM_SRC-1:0]                 pend_i,
    input  logic [NUM_SRC-1:0][PRIO_WIDTH-1:0] prio_i,
    output logic [ID_WIDTH-1:0]                win_idx_o,
    output logic                               win_any_o
);

    logic [PRIO_WIDTH-1:0] best;

    // Starting from best = 0 excludes disabled sources; strict '>' keeps the
    // lowest index among equal priorities.
    always_comb begin
        best      = '0;
        win_idx_o = '0;
        win_any_o = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pend_i[i] && (prio_i[i] > best)) begin
                best      = prio_i[i];
                win_idx_o = ID_WIDTH'(i);
                win_any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intp_prio_ctrl.sv
// intp_prio_ctrl: APB-programmable priority interrupt controller.
// Presents one granted source at a time and holds it until intp_serviced_i.
// Build option: define INTP_EDGE_DETECT_EN to add the MODE register and
// per-source sticky edge capture; otherwise every source is level-sensitive.
// Ports:
//   pclk_i, prst_i            clock, synchronous active-high reset
//   paddr_i .. perror_o       APB slave (registered pready/prdata/perror)
//   intp_active_i             request lines from peripherals
//   intp_valid_o              a grant is presented
//   intp_to_service_o         granted source index
//   intp_serviced_i           acknowledge of the current grant
module intp_prio_ctrl
    import intp_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 16,
    parameter int unsigned PRIO_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = id_width(NUM_SRC)
) (
    input  logic                  pclk_i,
    input  logic                  prst_i,
    input  logic [ADDR_WIDTH-1:0] paddr_i,
    input  logic                  pwrite_i,
    input  logic                  penable_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o,
    output logic                  perror_o,
    input  logic [NUM_SRC-1:0]    intp_active_i,
    output logic                  intp_valid_o,
    output logic [ID_WIDTH-1:0]   intp_to_service_o,
    input  logic                  intp_serviced_i
);

    localparam int unsigned PrioBase = prio_base();
    localparam int unsigned PendOfs  = pending_ofs(NUM_SRC);

    state_e                             state_q, state_d;
    logic [ID_WIDTH-1:0]                id_q, id_d;
    logic [NUM_SRC-1:0][PRIO_WIDTH-1:0] prio_q, prio_d;
    logic [NUM_SRC-1:0]                 level_q, level_d;
    logic [NUM_SRC-1:0]                 pend;
    logic                               pready_q, pready_d;
    logic                               perror_q, perror_d;
    logic [DATA_WIDTH-1:0]              prdata_q, prdata_d;
    logic [ID_WIDTH-1:0]                win_idx;
    logic                               win_any;
    logic                               service;
    logic                               unused_pwdata;

    assign unused_pwdata = ^pwdata_i;
    assign service       = (state_q == StGrant) && intp_serviced_i;
    // Sampled request lines; also the edge history in edge mode.
    assign level_d       = intp_active_i;

`ifdef INTP_EDGE_DETECT_EN
    localparam int unsigned ModeOfs = mode_ofs(NUM_SRC);

    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [NUM_SRC-1:0] edge_q, edge_d;

    // Clear on service first so a coincident new edge wins.
    always_comb begin
        edge_d = edge_q & mode_q;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (service && (id_q == ID_WIDTH'(i))) begin
                edge_d[i] = 1'b0;
            end
            if (mode_q[i] && intp_active_i[i] && !level_q[i]) begin
                edge_d[i] = 1'b1;
            end
        end
    end

    assign pend = (mode_q & edge_q) | (~mode_q & level_q);

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            mode_q <= '0;
            edge_q <= '0;
        end else begin
            mode_q <= mode_d;
            edge_q <= edge_d;
        end
    end
`else
    assign pend = level_q;
`endif

    // APB: complete one cycle after penable is first seen, then drop.
    always_comb begin
        pready_d = penable_i && !pready_q;
        perror_d = 1'b0;
        prdata_d = '0;
        prio_d   = prio_q;
`ifdef INTP_EDGE_DETECT_EN
        mode_d   = mode_q;
`endif
        if (pready_d) begin
            perror_d = 1'b1;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (paddr_i == ADDR_WIDTH'(PrioBase + i)) begin
                    perror_d = 1'b0;
                    if (pwrite_i) begin
                        prio_d[i] = pwdata_i[PRIO_WIDTH-1:0];
                    end else begin
                        prdata_d = DATA_WIDTH'(prio_q[i]);
                    end
                end
            end
            if ((paddr_i == ADDR_WIDTH'(PendOfs)) && !pwrite_i) begin
                perror_d = 1'b0;
                prdata_d = DATA_WIDTH'(pend);
            end
`ifdef INTP_EDGE_DETECT_EN
            if (paddr_i == ADDR_WIDTH'(ModeOfs)) begin
                perror_d = 1'b0;
                if (pwrite_i) begin
                    mode_d = pwdata_i[NUM_SRC-1:0];
                end else begin
                    prdata_d = DATA_WIDTH'(mode_q);
                end
            end
`endif
        end
    end

    intp_prio_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .PRIO_WIDTH(PRIO_WIDTH),
        .ID_WIDTH  (ID_WIDTH)
    ) u_arbiter (
        .pend_i   (pend),
        .prio_i   (prio_q),
        .win_idx_o(win_idx),
        .win_any_o(win_any)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        unique case (state_q)
            StIdle: begin
                if (win_any) begin
                    state_d = StSelect;
                end
            end
            StSelect: begin
                if (win_any) begin
                    id_d    = win_idx;
                    state_d = StGrant;
                end else begin
                    state_d = StIdle;
                end
            end
            StGrant: begin
                if (intp_serviced_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge pclk_i) begin
        if (prst_i) begin
            state_q  <= StIdle;
            id_q     <= '0;
            prio_q   <= '0;
            level_q  <= '0;
            pready_q <= 1'b0;
            perror_q <= 1'b0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            prio_q   <= prio_d;
            level_q  <= level_d;
            pready_q <= pready_d;
            perror_q <= perror_d;
            prdata_q <= prdata_d;
        end
    end

    assign prdata_o          = prdata_q;
    assign pready_o          = pready_q;
    assign perror_o          = perror_q;
    assign intp_valid_o      = (state_q == StGrant);
    assign intp_to_service_o = id_q;

endmodule

// File: tb/tb_intp_prio_ctrl.sv
module tb_intp_prio_ctrl;

    logic        clk;
    logic        prst;
    logic [5:0]  paddr;
    logic        pwrite;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        perror;
    logic [15:0] active;
    logic        valid;
    logic [3:0]  to_service;
    logic        serviced;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [5:0]  addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs[$];

    intp_prio_ctrl u_dut (
        .pclk_i           (clk),
        .prst_i           (prst),
        .paddr_i          (paddr),
        .pwrite_i         (pwrite),
        .penable_i        (penable),
        .pwdata_i         (pwdata),
        .prdata_o         (prdata),
        .pready_o         (pready),
        .perror_o         (perror),
        .intp_active_i    (active),
        .intp_valid_o     (valid),
        .intp_to_service_o(to_service),
        .intp_serviced_i  (serviced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic [5:0] a, input logic w, input logic [31:0] d,
                                input logic [31:0] rd, input logic e);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = d; v.rdata = rd; v.err = e;
        vecs.push_back(v);
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge following pready.
    task automatic apb(input logic [5:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output logic er);
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        penable = 1'b1;
        tick();
        check("pready_rise", 32'(pready), 32'd1);
        rd      = prdata;
        er      = perror;
        penable = 1'b0;
        tick();
        check("pready_pulse", 32'(pready), 32'd0);
    endtask

    task automatic apb_wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] rd;
        logic        er;
        apb(a, 1'b1, d, rd, er);
        check("wr_err", 32'(er), 32'd0);
    endtask

    task automatic apb_rd_chk(input string name, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        logic        er;
        apb(a, 1'b0, 32'd0, rd, er);
        check(name, rd, exp);
        check("rd_err", 32'(er), 32'd0);
    endtask

    task automatic wait_grant(input string name, input logic [31:0] exp_id);
        for (int i = 0; i < 10; i++) begin
            if (valid) break;
            tick();
        end
        check({name, "_valid"}, 32'(valid), 32'd1);
        check({name, "_id"}, 32'(to_service), exp_id);
    endtask

    // Acknowledge the current grant, optionally dropping a level line with it.
    task automatic service(input int drop_line);
        serviced = 1'b1;
        if (drop_line >= 0) active[drop_line] = 1'b0;
        tick();
        serviced = 1'b0;
        check("valid_after_service", 32'(valid), 32'd0);
    endtask

    task automatic run_table();
        logic [31:0] rd;
        logic        er;
        foreach (vecs[i]) begin
            apb(vecs[i].addr, vecs[i].wr, vecs[i].wdata, rd, er);
            check($sformatf("tbl%0d_data", i), rd, vecs[i].rdata);
            check($sformatf("tbl%0d_err", i), 32'(er), 32'(vecs[i].err));
        end
    endtask

    initial begin
        logic mode_err;
`ifdef INTP_EDGE_DETECT_EN
        mode_err = 1'b0;
`else
        mode_err = 1'b1;
`endif
        prst = 1'b1; paddr = '0; pwrite = 1'b0; penable = 1'b0; pwdata = '0;
        active = '0; serviced = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_id", 32'(to_service), 32'd0);
        check("rst_pready", 32'(pready), 32'd0);
        check("rst_perror", 32'(perror), 32'd0);
        check("rst_prdata", prdata, 32'd0);
        prst = 1'b0;
        tick();

        // Register map vectors
        for (int i = 0; i < 16; i++) add(6'(i), 1'b0, 32'd0, 32'd0, 1'b0);
        add(6'd16, 1'b0, 32'd0, 32'd0, 1'b0);
        add(6'd21, 1'b0, 32'd0, 32'd0, 1'b1);
        add(6'd16, 1'b1, 32'hFFFF, 32'd0, 1'b1);
        add(6'd16, 1'b0, 32'd0, 32'd0, 1'b0);
        add(6'd17, 1'b0, 32'd0, 32'd0, mode_err);
        add(6'd40, 1'b1, 32'h5, 32'd0, 1'b1);
        add(6'd5,  1'b1, 32'hFFF6, 32'd0, 1'b0);
        add(6'd5,  1'b0, 32'd0, 32'd6, 1'b0);
        add(6'd5,  1'b1, 32'd0, 32'd0, 1'b0);
        add(6'd5,  1'b0, 32'd0, 32'd0, 1'b0);
        add(6'd3,  1'b1, 32'd5, 32'd0, 1'b0);
        add(6'd9,  1'b1, 32'd12, 32'd0, 1'b0);
        add(6'd12, 1'b1, 32'd12, 32'd0, 1'b0);
        add(6'd9,  1'b0, 32'd0, 32'd12, 1'b0);
        run_table();

        // Tie-break and grant latency
        active[3] = 1'b1; active[9] = 1'b1; active[12] = 1'b1;
        tick();
        check("lat_k0", 32'(valid), 32'd0);
        tick();
        check("lat_k1", 32'(valid), 32'd0);
        tick();
        check("lat_k2_valid", 32'(valid), 32'd1);
        check("tie_id", 32'(to_service), 32'd9);
        service(9);
        tick();
        check("next_m1", 32'(valid), 32'd0);
        tick();
        check("next_m2_valid", 32'(valid), 32'd1);
        check("next_id12", 32'(to_service), 32'd12);
        service(12);
        wait_grant("g3", 32'd3);
        service(3);

        // Priority 0 disables a source
        active[7] = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("prio0_no_grant", 32'(valid), 32'd0);
        apb_rd_chk("pend7", 6'd16, 32'h80);
        apb_wr(6'd7, 32'd1);
        wait_grant("g7", 32'd7);
        service(7);

        // Sticky grant against higher priority, drop and priority change
        active[9] = 1'b1;
        wait_grant("g9", 32'd9);
        apb_wr(6'd2, 32'd15);
        active[2] = 1'b1;
        active[9] = 1'b0;
        apb_wr(6'd9, 32'd0);
        tick();
        check("sticky_valid", 32'(valid), 32'd1);
        check("sticky_id", 32'(to_service), 32'd9);
        service(-1);
        wait_grant("g2", 32'd2);
        service(2);
        apb_wr(6'd9, 32'd12);

`ifdef INTP_EDGE_DETECT_EN
        // Edge capture on source 4
        apb_wr(6'd4, 32'd3);
        apb_wr(6'd17, 32'h10);
        apb_rd_chk("mode_rd", 6'd17, 32'h10);
        active[4] = 1'b1;
        tick();
        active[4] = 1'b0;
        apb_rd_chk("edge_pend", 6'd16, 32'h10);
        wait_grant("g4", 32'd4);
        service(-1);
        apb_rd_chk("edge_cleared", 6'd16, 32'h0);
        // New edge coincident with service: set wins
        active[4] = 1'b1;
        tick();
        active[4] = 1'b0;
        wait_grant("g4b", 32'd4);
        tick();
        serviced  = 1'b1;
        active[4] = 1'b1;
        tick();
        serviced  = 1'b0;
        active[4] = 1'b0;
        check("set_wins_valid", 32'(valid), 32'd0);
        apb_rd_chk("set_wins_pend", 6'd16, 32'h10);
        wait_grant("g4c", 32'd4);
        service(-1);
        apb_rd_chk("edge_cleared2", 6'd16, 32'h0);
`endif

        // Reset in the middle of a grant
        active[3] = 1'b1;
        wait_grant("g3r", 32'd3);
        prst = 1'b1;
        tick();
        check("rst_mid_valid", 32'(valid), 32'd0);
        check("rst_mid_id", 32'(to_service), 32'd0);
        prst = 1'b0;
        active = '0;
        tick();
        for (int i = 0; i < 17; i++) apb_rd_chk($sformatf("post_rst_%0d", i), 6'(i), 32'd0);
`ifdef INTP_EDGE_DETECT_EN
        apb_rd_chk("post_rst_mode", 6'd17, 32'd0);
`endif
        check("post_rst_idle", 32'(valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
